// File: rtl/rob.sv
// Reorder buffer: circular queue of in-flight instructions, allocated in
// program order, completed out of order by RS/LSB results, retired in order.
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (pause when low)
//   issue_*      : decoder allocation at tail; issue_tag/rob_full combinational
//   rs_wb_*      : RS result (value, jalr target pc)
//   lsb_wb_*     : LSB result (load data / store address resolved)
//   query_*      : combinational operand lookups with same-cycle bypass
//   commit_*     : registered register-file write
//   store_*      : registered store release
//   clear_all    : registered flush pulse, new_PC valid while it is high
module rob #(
  parameter int unsigned ROB_WIDTH_BIT = 3,
  parameter int unsigned REG_ID_BIT    = 5
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     issue_valid,
  input  logic [1:0]               issue_type,
  input  logic [REG_ID_BIT-1:0]    issue_rd,
  input  logic                     issue_pred_taken,
  input  logic [31:0]              issue_alt_pc,
  output logic [ROB_WIDTH_BIT-1:0] issue_tag,
  output logic                     rob_full,
  input  logic                     rs_wb_valid,
  input  logic [ROB_WIDTH_BIT-1:0] rs_wb_tag,
  input  logic [31:0]              rs_wb_value,
  input  logic [31:0]              rs_wb_pc,
  input  logic                     lsb_wb_valid,
  input  logic [ROB_WIDTH_BIT-1:0] lsb_wb_tag,
  input  logic [31:0]              lsb_wb_value,
  input  logic [ROB_WIDTH_BIT-1:0] query_tag_j,
  input  logic [ROB_WIDTH_BIT-1:0] query_tag_k,
  output logic                     query_ready_j,
  output logic                     query_ready_k,
  output logic [31:0]              query_value_j,
  output logic [31:0]              query_value_k,
  output logic                     commit_valid,
  output logic [REG_ID_BIT-1:0]    commit_rd,
  output logic [31:0]              commit_value,
  output logic [ROB_WIDTH_BIT-1:0] commit_tag,
  output logic                     store_commit,
  output logic [ROB_WIDTH_BIT-1:0] store_tag,
  output logic                     clear_all,
  output logic [31:0]              new_PC
);

  localparam int unsigned DEPTH = 1 << ROB_WIDTH_BIT;
  localparam int unsigned CNT_W = ROB_WIDTH_BIT + 1;

  typedef enum logic [1:0] {
    T_REG  = 2'd0,
    T_BR   = 2'd1,
    T_ST   = 2'd2,
    T_JALR = 2'd3
  } rob_type_e;

  logic [DEPTH-1:0]         busy_q;
  logic [DEPTH-1:0]         ready_q;
  rob_type_e                type_q  [DEPTH];
  logic [REG_ID_BIT-1:0]    rd_q    [DEPTH];
  logic                     pred_q  [DEPTH];
  logic [31:0]              alt_q   [DEPTH];
  logic [31:0]              value_q [DEPTH];
  logic [31:0]              jpc_q   [DEPTH];

  logic [ROB_WIDTH_BIT-1:0] head_q;
  logic [ROB_WIDTH_BIT-1:0] tail_q;
  logic [CNT_W-1:0]         count_q;

  logic active;
  logic do_commit;
  logic do_flush;
  logic do_issue;
  logic rs_take;
  logic lsb_take;

  assign issue_tag = tail_q;
  assign rob_full  = (count_q == CNT_W'(DEPTH));

  // Per-cycle control decisions; everything is frozen while paused or flushing.
  always_comb begin
    active    = rdy_in & ~clear_all;
    do_commit = busy_q[head_q] & ready_q[head_q];
    do_flush  = do_commit &
                ((type_q[head_q] == T_JALR) |
                 ((type_q[head_q] == T_BR) & (value_q[head_q][0] != pred_q[head_q])));
    do_issue  = issue_valid & ~rob_full;
    rs_take   = rs_wb_valid & busy_q[rs_wb_tag];
    // RS wins when both units target the same tag
    lsb_take  = lsb_wb_valid & busy_q[lsb_wb_tag] &
                ~(rs_wb_valid & (rs_wb_tag == lsb_wb_tag));
  end

  // Operand lookup: same-cycle result bypass first, then stored completed value.
  function automatic logic [32:0] lookup(input logic [ROB_WIDTH_BIT-1:0] t);
    logic [32:0] r;
    r = '0;
    if (rs_wb_valid && rs_wb_tag == t)          r = {1'b1, rs_wb_value};
    else if (lsb_wb_valid && lsb_wb_tag == t)   r = {1'b1, lsb_wb_value};
    else if (busy_q[t] && ready_q[t])           r = {1'b1, value_q[t]};
    return r;
  endfunction

  always_comb begin
    {query_ready_j, query_value_j} = lookup(query_tag_j);
    {query_ready_k, query_value_k} = lookup(query_tag_k);
  end

  // Entry payload; qualified by busy, so it needs no reset.
  always_ff @(posedge clk_in) begin
    if (active) begin
      if (do_issue && !do_flush) begin
        type_q[tail_q] <= rob_type_e'(issue_type);
        rd_q[tail_q]   <= issue_rd;
        pred_q[tail_q] <= issue_pred_taken;
        alt_q[tail_q]  <= issue_alt_pc;
      end
      if (rs_take) begin
        value_q[rs_wb_tag] <= rs_wb_value;
        jpc_q[rs_wb_tag]   <= rs_wb_pc;
      end
      if (lsb_take) value_q[lsb_wb_tag] <= lsb_wb_value;
    end
  end

  // Queue control and registered retire outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q       <= '0;
      ready_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      commit_valid <= 1'b0;
      commit_rd    <= '0;
      commit_value <= '0;
      commit_tag   <= '0;
      store_commit <= 1'b0;
      store_tag    <= '0;
      clear_all    <= 1'b0;
      new_PC       <= '0;
    end else begin
      commit_valid <= 1'b0;
      store_commit <= 1'b0;
      clear_all    <= 1'b0;
      if (active) begin
        if (rs_take)  ready_q[rs_wb_tag]  <= 1'b1;
        if (lsb_take) ready_q[lsb_wb_tag] <= 1'b1;
        if (do_issue) begin
          busy_q[tail_q]  <= 1'b1;
          ready_q[tail_q] <= 1'b0;
        end
        if (do_commit) begin
          busy_q[head_q] <= 1'b0;
          case (type_q[head_q])
            T_REG: begin
              commit_valid <= 1'b1;
              commit_rd    <= rd_q[head_q];
              commit_value <= value_q[head_q];
              commit_tag   <= head_q;
            end
            T_BR: begin
              if (value_q[head_q][0] != pred_q[head_q]) begin
                clear_all <= 1'b1;
                new_PC    <= alt_q[head_q];
              end
            end
            T_ST: begin
              store_commit <= 1'b1;
              store_tag    <= head_q;
            end
            T_JALR: begin
              commit_valid <= 1'b1;
              commit_rd    <= rd_q[head_q];
              commit_value <= value_q[head_q];
              commit_tag   <= head_q;
              clear_all    <= 1'b1;
              new_PC       <= jpc_q[head_q];
            end
          endcase
        end
        if (do_flush) begin
          busy_q  <= '0;
          head_q  <= '0;
          tail_q  <= '0;
          count_q <= '0;
        end else begin
          if (do_issue)  tail_q <= tail_q + ROB_WIDTH_BIT'(1);
          if (do_commit) head_q <= head_q + ROB_WIDTH_BIT'(1);
          case ({do_issue, do_commit})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_rob.sv
// Randomized + directed bench for rob: a queue-based program-order model
// predicts retire pulses into a scoreboard; a negedge monitor checks them.
module tb_rob;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b0;
  logic        issue_valid = 1'b0;
  logic [1:0]  issue_type = '0;
  logic [4:0]  issue_rd = '0;
  logic        issue_pred_taken = 1'b0;
  logic [31:0] issue_alt_pc = '0;
  logic [2:0]  issue_tag;
  logic        rob_full;
  logic        rs_wb_valid = 1'b0;
  logic [2:0]  rs_wb_tag = '0;
  logic [31:0] rs_wb_value = '0;
  logic [31:0] rs_wb_pc = '0;
  logic        lsb_wb_valid = 1'b0;
  logic [2:0]  lsb_wb_tag = '0;
  logic [31:0] lsb_wb_value = '0;
  logic [2:0]  query_tag_j = '0;
  logic [2:0]  query_tag_k = '0;
  logic        query_ready_j, query_ready_k;
  logic [31:0] query_value_j, query_value_k;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic [2:0]  commit_tag;
  logic        store_commit;
  logic [2:0]  store_tag;
  logic        clear_all;
  logic [31:0] new_PC;

  rob dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
    .issue_tag(issue_tag), .rob_full(rob_full),
    .rs_wb_valid(rs_wb_valid), .rs_wb_tag(rs_wb_tag), .rs_wb_value(rs_wb_value),
    .rs_wb_pc(rs_wb_pc),
    .lsb_wb_valid(lsb_wb_valid), .lsb_wb_tag(lsb_wb_tag), .lsb_wb_value(lsb_wb_value),
    .query_tag_j(query_tag_j), .query_tag_k(query_tag_k),
    .query_ready_j(query_ready_j), .query_ready_k(query_ready_k),
    .query_value_j(query_value_j), .query_value_k(query_value_k),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
    .commit_tag(commit_tag), .store_commit(store_commit), .store_tag(store_tag),
    .clear_all(clear_all), .new_PC(new_PC)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [2:0]  tag;
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic        pred;
    logic [31:0] alt;
    logic [31:0] val;
    logic [31:0] jpc;
    logic        done;
  } ent_t;

  typedef struct {
    int          stamp;
    logic        cv;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [2:0]  tag;
    logic        sc;
    logic [2:0]  stag;
    logic        ca;
    logic [31:0] npc;
  } ev_t;

  ent_t       mq[$];
  ev_t        sb[$];
  logic [2:0] mtail = '0;
  bit         clr_pend = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         edge_cnt = 0;

  always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected lookup from the model: bypass (RS first), else completed entry.
  task automatic qexp(input logic [2:0] t, output logic r, output logic [31:0] v);
    r = 1'b0; v = '0;
    if (rs_wb_valid && rs_wb_tag == t) begin r = 1'b1; v = rs_wb_value; end
    else if (lsb_wb_valid && lsb_wb_tag == t) begin r = 1'b1; v = lsb_wb_value; end
    else foreach (mq[i]) if (mq[i].tag == t && mq[i].done) begin r = 1'b1; v = mq[i].val; end
  endtask

  // Advance the program-order model by one clock edge using the driven inputs.
  task automatic model_update();
    ent_t h;
    ev_t  e;
    bit   have_c, full_pre;
    if (!rdy_in || clr_pend) begin clr_pend = 1'b0; return; end
    full_pre = (mq.size() == 8);
    have_c = (mq.size() > 0) && mq[0].done;
    if (have_c) h = mq[0];
    for (int i = 0; i < mq.size(); i++) begin
      if (rs_wb_valid && mq[i].tag == rs_wb_tag) begin
        mq[i].val = rs_wb_value; mq[i].jpc = rs_wb_pc; mq[i].done = 1'b1;
      end
      if (lsb_wb_valid && !(rs_wb_valid && rs_wb_tag == lsb_wb_tag) && mq[i].tag == lsb_wb_tag) begin
        mq[i].val = lsb_wb_value; mq[i].done = 1'b1;
      end
    end
    if (have_c) begin
      void'(mq.pop_front());
      e.stamp = edge_cnt + 1;
      e.cv = 1'b0; e.rd = '0; e.val = '0; e.tag = '0;
      e.sc = 1'b0; e.stag = '0; e.ca = 1'b0; e.npc = '0;
      case (h.typ)
        2'd0: begin e.cv = 1'b1; e.rd = h.rd; e.val = h.val; e.tag = h.tag; end
        2'd1: if (h.val[0] != h.pred) begin e.ca = 1'b1; e.npc = h.alt; end
        2'd2: begin e.sc = 1'b1; e.stag = h.tag; end
        default: begin
          e.cv = 1'b1; e.rd = h.rd; e.val = h.val; e.tag = h.tag;
          e.ca = 1'b1; e.npc = h.jpc;
        end
      endcase
      if (e.cv || e.sc || e.ca) sb.push_back(e);
      if (e.ca) begin
        mq.delete(); mtail = '0; clr_pend = 1'b1;
        return;
      end
    end
    if (issue_valid && !full_pre) begin
      h.tag = mtail; h.typ = issue_type; h.rd = issue_rd; h.pred = issue_pred_taken;
      h.alt = issue_alt_pc; h.val = '0; h.jpc = '0; h.done = 1'b0;
      mq.push_back(h);
      mtail = mtail + 3'd1;
    end
  endtask

  // Check combinational outputs, update the model, then move to the next negedge.
  task automatic step();
    logic        r;
    logic [31:0] v;
    #1;
    chk("issue_tag", 32'(issue_tag), 32'(mtail));
    chk("rob_full", 32'(rob_full), 32'(mq.size() == 8));
    qexp(query_tag_j, r, v);
    chk("query_ready_j", 32'(query_ready_j), 32'(r));
    chk("query_value_j", query_value_j, v);
    qexp(query_tag_k, r, v);
    chk("query_ready_k", 32'(query_ready_k), 32'(r));
    chk("query_value_k", query_value_k, v);
    model_update();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  // Monitor: every retire pulse must match the scoreboard entry for this edge.
  always @(negedge clk_in) begin
    ev_t e;
    if (rst_in) begin
      while (sb.size() > 0 && sb[0].stamp < edge_cnt) begin
        n_tests++; n_fail++;
        $display("FAIL missing_retire: got no pulse expected cv=%0b sc=%0b ca=%0b tag=%0d at edge %0d",
                 sb[0].cv, sb[0].sc, sb[0].ca, sb[0].tag, sb[0].stamp);
        void'(sb.pop_front());
      end
      if (commit_valid || store_commit || clear_all) begin
        n_tests++;
        if (sb.size() > 0 && sb[0].stamp == edge_cnt) begin
          e = sb.pop_front();
          if (commit_valid !== e.cv || store_commit !== e.sc || clear_all !== e.ca ||
              (e.cv && (commit_rd !== e.rd || commit_value !== e.val || commit_tag !== e.tag)) ||
              (e.sc && store_tag !== e.stag) || (e.ca && new_PC !== e.npc)) begin
            n_fail++;
            $display("FAIL retire: got cv=%0b rd=%0d val=%0h tag=%0d sc=%0b stag=%0d ca=%0b pc=%0h expected cv=%0b rd=%0d val=%0h tag=%0d sc=%0b stag=%0d ca=%0b pc=%0h",
                     commit_valid, commit_rd, commit_value, commit_tag, store_commit, store_tag, clear_all, new_PC,
                     e.cv, e.rd, e.val, e.tag, e.sc, e.stag, e.ca, e.npc);
          end
        end else begin
          n_fail++;
          $display("FAIL unexpected_retire: got cv=%0b sc=%0b ca=%0b tag=%0d expected no pulse at edge %0d",
                   commit_valid, store_commit, clear_all, commit_tag, edge_cnt);
        end
      end
    end
  end

  task automatic idle();
    rdy_in = 1'b1; issue_valid = 1'b0; rs_wb_valid = 1'b0; lsb_wb_valid = 1'b0;
  endtask

  task automatic iss(input logic [1:0] t, input logic [4:0] rd, input logic p, input logic [31:0] a);
    idle();
    issue_valid = 1'b1; issue_type = t; issue_rd = rd; issue_pred_taken = p; issue_alt_pc = a;
    step();
  endtask

  task automatic chk_reset_outputs(input string tagname);
    chk({tagname, "_commit_valid"}, 32'(commit_valid), 0);
    chk({tagname, "_commit_rd"}, 32'(commit_rd), 0);
    chk({tagname, "_commit_value"}, commit_value, 0);
    chk({tagname, "_commit_tag"}, 32'(commit_tag), 0);
    chk({tagname, "_store_commit"}, 32'(store_commit), 0);
    chk({tagname, "_store_tag"}, 32'(store_tag), 0);
    chk({tagname, "_clear_all"}, 32'(clear_all), 0);
    chk({tagname, "_new_PC"}, new_PC, 0);
    chk({tagname, "_issue_tag"}, 32'(issue_tag), 0);
    chk({tagname, "_rob_full"}, 32'(rob_full), 0);
  endtask

  task automatic do_reset();
    #2;
    rst_in = 1'b0;
    #1;
    chk_reset_outputs("reset_mid");
    mq.delete(); sb.delete(); mtail = '0; clr_pend = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  // Complete every outstanding entry via RS writebacks until the model is empty.
  task automatic drain();
    int guard;
    guard = 0;
    while ((mq.size() > 0 || clr_pend) && guard < 200) begin
      idle();
      for (int i = 0; i < mq.size(); i++) begin
        if (!mq[i].done) begin
          rs_wb_valid = 1'b1; rs_wb_tag = mq[i].tag;
          rs_wb_value = (mq[i].typ == 2'd1) ? {31'h0, mq[i].pred} : $urandom;
          rs_wb_pc = $urandom;
          break;
        end
      end
      step();
      guard++;
    end
    n_tests++;
    if (guard >= 200) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d entries left expected 0", mq.size());
    end
    idle(); step(); step();
  endtask

  initial begin
    logic [31:0] v;
    int          r, i, j;
    logic [2:0]  t;
    bit          hit;

    #1;
    chk_reset_outputs("reset_init");
    @(negedge clk_in);
    rst_in = 1'b1;
    idle(); step();

    // Fill to 8, ninth issue dropped, reverse-order completion, in-order retire.
    for (int k = 0; k < 8; k++) iss(2'd0, 5'(k + 1), 1'b0, 32'h0);
    chk("fill_full", 32'(rob_full), 1);
    iss(2'd0, 5'd31, 1'b0, 32'h0);
    for (int k = 7; k >= 0; k--) begin
      idle(); lsb_wb_valid = 1'b1; lsb_wb_tag = 3'(k); lsb_wb_value = 32'h100 + 32'(k);
      step();
    end
    idle();
    for (int k = 0; k < 9; k++) step();
    chk("wrap_tag0", 32'(issue_tag), 0);
    iss(2'd0, 5'd9, 1'b0, 32'h0);
    chk("wrap_tag1", 32'(issue_tag), 1);
    iss(2'd2, 5'd0, 1'b0, 32'h0);
    drain();

    // Mispredicted branch with three younger completed entries.
    iss(2'd1, 5'd0, 1'b1, 32'h104);
    for (int k = 0; k < 3; k++) iss(2'd0, 5'(k + 10), 1'b0, 32'h0);
    for (int k = 1; k < 4; k++) begin
      idle(); lsb_wb_valid = 1'b1; lsb_wb_tag = mq[k].tag; lsb_wb_value = 32'h55 + 32'(k);
      step();
    end
    idle(); rs_wb_valid = 1'b1; rs_wb_tag = mq[0].tag; rs_wb_value = 32'h0; rs_wb_pc = 32'h0;
    step();
    idle(); step();
    chk("mispredict_new_pc", new_PC, 32'h104);
    step(); step();
    chk("mispredict_tail", 32'(issue_tag), 0);

    // jalr: link write and redirect in the same pulse.
    iss(2'd3, 5'd1, 1'b0, 32'h0);
    idle(); rs_wb_valid = 1'b1; rs_wb_tag = 3'd0; rs_wb_value = 32'h2008; rs_wb_pc = 32'h3000;
    step();
    idle(); step();
    chk("jalr_rd", 32'(commit_rd), 1);
    chk("jalr_value", commit_value, 32'h2008);
    chk("jalr_pc", new_PC, 32'h3000);
    step(); step();

    // Simultaneous RS/LSB results with bypassed query.
    for (int k = 0; k < 4; k++) iss(2'd0, 5'(k + 20), 1'b0, 32'h0);
    idle();
    rs_wb_valid = 1'b1; rs_wb_tag = 3'd2; rs_wb_value = 32'hAAAA; rs_wb_pc = 32'h0;
    lsb_wb_valid = 1'b1; lsb_wb_tag = 3'd3; lsb_wb_value = 32'hBBBB;
    query_tag_j = 3'd2; query_tag_k = 3'd3;
    #1;
    chk("simul_ready_j", 32'(query_ready_j), 1);
    chk("simul_value_j", query_value_j, 32'hAAAA);
    step();
    idle();
    rs_wb_valid = 1'b1; rs_wb_tag = 3'd0; rs_wb_value = 32'h1111;
    lsb_wb_valid = 1'b1; lsb_wb_tag = 3'd0; lsb_wb_value = 32'h2222;
    query_tag_j = 3'd0;
    step();
    idle(); rs_wb_valid = 1'b1; rs_wb_tag = 3'd1; rs_wb_value = 32'h3333;
    step();
    idle();
    for (int k = 0; k < 6; k++) step();

    // Pause with a ready head: single commit after resume.
    iss(2'd0, 5'd7, 1'b0, 32'h0);
    idle(); lsb_wb_valid = 1'b1; lsb_wb_tag = mq[0].tag; lsb_wb_value = 32'h77;
    step();
    idle(); rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) step();
    idle(); step();
    chk("pause_commit_value", commit_value, 32'h77);
    step(); step();

    // Randomized traffic with a mid-run reset.
    for (int c = 0; c < 800; c++) begin
      if (c == 400) do_reset();
      idle();
      rdy_in = ($urandom_range(0, 9) != 0);
      issue_valid = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 9);
      issue_type = (r < 5) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      issue_rd = 5'($urandom); issue_pred_taken = 1'($urandom); issue_alt_pc = $urandom;
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
        i = $urandom_range(0, mq.size() - 1);
        if (!mq[i].done && (mq[i].typ == 2'd1 || mq[i].typ == 2'd3 || $urandom_range(0, 1) == 1)) begin
          v = $urandom;
          if (mq[i].typ == 2'd1) v[0] = ($urandom_range(0, 3) != 0) ? mq[i].pred : ~mq[i].pred;
          rs_wb_valid = 1'b1; rs_wb_tag = mq[i].tag; rs_wb_value = v; rs_wb_pc = $urandom;
        end
        j = $urandom_range(0, mq.size() - 1);
        if (!mq[j].done && (mq[j].typ == 2'd0 || mq[j].typ == 2'd2 ||
                            (rs_wb_valid && rs_wb_tag == mq[j].tag))) begin
          lsb_wb_valid = 1'b1; lsb_wb_tag = mq[j].tag; lsb_wb_value = $urandom;
        end
      end
      if (!lsb_wb_valid && $urandom_range(0, 19) == 0) begin
        t = 3'($urandom);
        hit = 1'b0;
        foreach (mq[q]) if (mq[q].tag == t) hit = 1'b1;
        if (!hit) begin lsb_wb_valid = 1'b1; lsb_wb_tag = t; lsb_wb_value = $urandom; end
      end
      query_tag_j = (rs_wb_valid && $urandom_range(0, 1) == 1) ? rs_wb_tag : 3'($urandom);
      query_tag_k = (lsb_wb_valid && $urandom_range(0, 1) == 1) ? lsb_wb_tag : 3'($urandom);
      step();
    end
    drain();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
